// File: rtl/stream_mux_arb_pkg.sv
// stream_mux_pkg: shared mode encodings and round-robin pointer helper for stream_mux_arb
package stream_mux_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
  function automatic int rr_next(input int g, input int n);
    return (g == n - 1) ? 0 : g + 1;
  endfunction
endpackage

// File: rtl/stream_mux_arb_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, first requester at or above ptr wins (wrapping)
// ports: req (per-channel request), ptr (search start), en (0 forces no grant), grant (one-hot or zero)
module rr_arbiter #(
  parameter int N_CH = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             en,
  output logic [N_CH-1:0]  grant
);
  logic [N_CH-1:0] rot;
  logic [N_CH-1:0] pe;
  always_comb begin
    rot   = N_CH'({req, req} >> ptr);
    pe    = rot & (~rot + N_CH'(1));
    grant = en ? N_CH'(({pe, pe} << ptr) >> N_CH) : '0;
  end
endmodule

// File: rtl/stream_mux_arb.sv
// stream_mux_arb: N-channel valid/ready stream mux with fixed-select or round-robin arbitration and a registered output
// ports: clk, rst_n (async active-low); mode (0 fixed, 1 round-robin), sel (fixed-mode channel);
//        in_data/in_valid/in_ready (per-channel handshake, channel k at [k*WIDTH +: WIDTH]);
//        out_data/out_ch/out_valid (registered beat and its source channel), out_ready (downstream)
module stream_mux_arb
  import stream_mux_pkg::*;
#(
  parameter int N_CH = 8,
  parameter int WIDTH = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  output logic                  out_valid,
  input  logic                  out_ready
);
  logic             load;
  logic             xfer;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] gidx;
  logic [WIDTH-1:0] gdata;
  logic [N_CH-1:0]  grant_rr;
  logic [N_CH-1:0]  grant_fx;
  logic [N_CH-1:0]  grant;
  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req  (in_valid),
    .ptr  (rr_ptr),
    .en   (mode == MODE_RR),
    .grant(grant_rr)
  );
  // out-of-range sel shifts the bit off the top, leaving no grant
  assign grant_fx = in_valid & (N_CH'(1) << sel);
  assign grant    = (mode == MODE_RR) ? grant_rr : grant_fx;
  assign load     = !out_valid || out_ready;
  assign in_ready = load ? grant : '0;
  assign xfer     = |in_ready;
  always_comb begin
    gidx  = '0;
    gdata = '0;
    for (int k = 0; k < N_CH; k++)
      if (grant[k]) begin
        gidx  = SEL_W'(k);
        gdata = in_data[k*WIDTH +: WIDTH];
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else begin
      if (load) out_valid <= xfer;
      if (xfer) begin
        out_data <= gdata;
        out_ch   <= gidx;
      end
      if (xfer && mode == MODE_RR) rr_ptr <= SEL_W'(rr_next(int'(gidx), N_CH));
    end
endmodule

// File: tb/tb_stream_mux_arb.sv
// tb_stream_mux_arb: randomized scoreboard bench for stream_mux_arb against a behavioural handshake model
module tb_stream_mux_arb;
  localparam int N = 8;
  localparam int W = 8;
  typedef struct packed {
    logic [2:0] ch;
    logic [7:0] d;
  } beat_t;
  logic         clk = 0;
  logic         rst_n = 0;
  logic         mode = 0;
  logic [2:0]   sel = 0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0] in_valid = '0;
  logic [N-1:0] in_ready;
  logic [W-1:0] out_data;
  logic [2:0]   out_ch;
  logic         out_valid;
  logic         out_ready = 0;
  int tests = 0;
  int fails = 0;
  beat_t sb[$];
  logic [N-1:0] pend = '0;
  logic [7:0]   pdata[N];
  int  ptr = 0;
  logic mv = 0;
  logic mv_nxt = 0;
  stream_mux_arb #(.N_CH(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cycle(input logic m, input logic [2:0] s, input logic [N-1:0] offer, input logic ordy);
    int g;
    logic ld;
    @(posedge clk);
    #2;
    mv = mv_nxt;
    for (int k = 0; k < N; k++)
      if (offer[k] && !pend[k]) begin
        pend[k]  = 1'b1;
        pdata[k] = 8'($urandom);
      end
    for (int k = 0; k < N; k++) in_data[k*W +: W] = pdata[k];
    in_valid  = pend;
    mode      = m;
    sel       = s;
    out_ready = ordy;
    #1;
    ld = !mv || ordy;
    g  = -1;
    if (ld && rst_n) begin
      if (!m) begin
        if (pend[s]) g = int'(s);
      end else
        for (int i = 0; i < N; i++)
          if (g < 0 && pend[(ptr + i) % N]) g = (ptr + i) % N;
    end
    chk("in_ready", 32'(in_ready), (g >= 0) ? 32'(1) << g : 32'd0);
    if (g >= 0) begin
      sb.push_back('{ch: 3'(g), d: pdata[g]});
      pend[g] = 1'b0;
      if (m) ptr = (g + 1) % N;
    end
    mv_nxt = ld ? (g >= 0) : mv;
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && pend != 0; i++) cycle(1'b1, 3'd0, '0, 1'b1);
    cycle(1'b1, 3'd0, '0, 1'b1);
    cycle(1'b1, 3'd0, '0, 1'b1);
  endtask
  task automatic reset_now();
    rst_n = 0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_ch", 32'(out_ch), 0);
    sb.delete();
    pend = '0;
    in_valid = '0;
    mv = 0;
    mv_nxt = 0;
    ptr = 0;
    cycle(1'b1, 3'd0, '0, 1'b1);
    cycle(1'b1, 3'd0, '0, 1'b1);
    rst_n = 1;
  endtask
  initial begin : monitor
    logic       stalled;
    logic [7:0] hd;
    logic [2:0] hc;
    beat_t      e;
    stalled = 0;
    forever begin
      @(negedge clk);
      chk("out_valid", 32'(out_valid), 32'(mv));
      if (stalled && rst_n) begin
        chk("stall_data", 32'(out_data), 32'(hd));
        chk("stall_ch", 32'(out_ch), 32'(hc));
      end
      stalled = rst_n && out_valid && !out_ready;
      hd = out_data;
      hc = out_ch;
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 32'(out_valid), 0);
        else begin
          e = sb.pop_front();
          chk("out_data", 32'(out_data), 32'(e.d));
          chk("out_ch", 32'(out_ch), 32'(e.ch));
        end
      end
    end
  end
  initial begin
    for (int k = 0; k < N; k++) pdata[k] = '0;
    reset_now();
    pend[3] = 1'b1;
    pdata[3] = 8'hA5;
    cycle(1'b0, 3'd3, 8'h08, 1'b1);
    cycle(1'b0, 3'd3, '0, 1'b1);
    repeat (9) cycle(1'b1, 3'd0, 8'hFF, 1'b1);
    drain();
    repeat (6) cycle(1'b1, 3'd0, 8'h81, 1'b1);
    drain();
    cycle(1'b1, 3'd0, 8'hFF, 1'b1);
    repeat (3) cycle(1'b1, 3'd0, 8'hFF, 1'b0);
    repeat (3) cycle(1'b1, 3'd0, 8'hFF, 1'b1);
    drain();
    repeat (2) cycle(1'b0, 3'd2, 8'hFB, 1'b1);
    repeat (3) cycle(1'b1, 3'd2, 8'hFB, 1'b1);
    drain();
    cycle(1'b1, 3'd0, 8'hFF, 1'b1);
    cycle(1'b1, 3'd0, 8'hFF, 1'b0);
    reset_now();
    repeat (4) cycle(1'b1, 3'd0, 8'hFF, 1'b1);
    drain();
    repeat (400) cycle(1'($urandom), 3'($urandom), N'($urandom), ($urandom_range(0, 3) != 0));
    drain();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
